// File: rtl/div_share_ctrl_pkg.sv
// Shared constants and index helpers for the divider-sharing scheduler.
// The divider width and latency live here so the divider wrapper and the
// scheduler can never disagree about them.
package div_share_ctrl_pkg;

    localparam int DIV_DW      = 36;
    localparam int DIV_LAT_CYC = 3;
    localparam int MAX_ID_W    = 3;

    // One tag pipeline entry: whether a divider op is in flight and who issued it
    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Cyclic index: ptr + ofs folded back into 0..n-1 (ofs < n)
    function automatic int rr_index(input int ptr, input int ofs, input int n);
        int v;
        v = ptr + ofs;
        if (v >= n) v = v - n;
        return v;
    endfunction

    // Successor of v in a ring of n entries
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Requester-side bus of the divider-sharing scheduler: request handshake
// with packed operands, and the broadcast result with a one-hot strobe.
interface div_share_ctrl_if import div_share_ctrl_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int DW    = DIV_DW
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    res_valid;
    logic [DW-1:0]       res_q;
    logic [DW-1:0]       res_r;
    logic                res_err;

    // Requester side
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_q, res_r, res_err
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_q, res_r, res_err
    );

endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus encoded ID, with the
// priority pointer moving just past the winner whenever a grant is taken.
module rr_arbiter import div_share_ctrl_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gid
);

    logic [ID_W-1:0] ptr;
    logic            found;

    // Grant the first pending requester at or after the pointer, wrapping around
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == rr_index(int'(ptr), i, N_REQ))) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    gid      = ID_W'(j);
                end
            end
        end
    end

    // Move the pointer past the winner so it drops to lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ID_W'(wrap_inc(int'(gid), N_REQ));
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one pipelined divider between N_REQ requesters. One request is
// issued per cycle, the requester ID rides a tag pipeline matched to the
// divider latency, and the result is registered back to the issuer.
// The divider instance itself sits outside; its rst_n is ~rst.
module div_share_ctrl import div_share_ctrl_pkg::*; #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int DW      = DIV_DW,
    parameter int DIV_LAT = DIV_LAT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    div_share_ctrl_if.slave   bus,
    output logic              busy,
    output logic              div_valid,
    output logic [DW-1:0]     div_a,
    output logic [DW-1:0]     div_b,
    input  logic [DW-1:0]     div_q,
    input  logic [DW-1:0]     div_r,
    input  logic              div_ready,
    input  logic              div_inv
);

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gid;
    logic             any_grant;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic [DW-1:0]    last_a_p0;
    logic [DW-1:0]    last_b_p0;
    tag_t             tag_p [DIV_LAT];
    logic [N_REQ-1:0] out_oh;
    logic [N_REQ-1:0] res_valid_r;
    logic [DW-1:0]    res_q_r;
    logic [DW-1:0]    res_r_r;
    logic             res_err_r;

    // With en low nobody can win, but in-flight work keeps draining
    assign arb_req = bus.req_valid & {N_REQ{en}};

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (any_grant),
        .grant   (grant),
        .gid     (gid)
    );

    assign any_grant     = |grant;
    assign bus.req_ready = grant;

    // Operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[i*DW +: DW];
                sel_b = bus.req_b[i*DW +: DW];
            end
        end
    end

    // Keep the last issued operands so the divider inputs stay quiet when idle
    always_ff @(posedge clk) begin
        if (any_grant) begin
            last_a_p0 <= sel_a;
            last_b_p0 <= sel_b;
        end
    end

    assign div_valid = any_grant;
    assign div_a     = any_grant ? sel_a : last_a_p0;
    assign div_b     = any_grant ? sel_b : last_b_p0;

    // ---- issue -> tag stage 0 .. DIV_LAT-1 (aligned with div_ready) ----
    // Shift the {vld, id} tag alongside the divider pipeline every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DIV_LAT; k++) tag_p[k].vld <= 1'b0;
        end else begin
            tag_p[0].vld <= any_grant;
            for (int k = 1; k < DIV_LAT; k++) tag_p[k].vld <= tag_p[k-1].vld;
        end
        tag_p[0].id <= MAX_ID_W'(gid);
        for (int k = 1; k < DIV_LAT; k++) tag_p[k].id <= tag_p[k-1].id;
    end

    // Decode the returning tag into the one-hot result strobe
    always_comb begin
        out_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            out_oh[i] = (tag_p[DIV_LAT-1].id == MAX_ID_W'(i));
        end
    end

    // ---- tag stage DIV_LAT-1 -> result register ----
    // Capture the divider output for the tagged requester; the tag, not
    // div_ready, decides whether a result is real
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= '0;
            res_q_r     <= '0;
            res_r_r     <= '0;
            res_err_r   <= 1'b0;
        end else begin
            res_valid_r <= tag_p[DIV_LAT-1].vld ? out_oh : '0;
            if (tag_p[DIV_LAT-1].vld) begin
                if (div_inv) begin
                    res_q_r   <= '0;
                    res_r_r   <= '0;
                    res_err_r <= 1'b1;
                end else begin
                    res_q_r   <= div_q;
                    res_r_r   <= div_r;
                    res_err_r <= 1'b0;
                end
            end
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_q     = res_q_r;
    assign bus.res_r     = res_r_r;
    assign bus.res_err   = res_err_r;

    // Busy while anything is in the tag pipeline or a result is being presented
    always_comb begin
        busy = |res_valid_r;
        for (int k = 0; k < DIV_LAT; k++) busy = busy | tag_p[k].vld;
    end

    // The divider's ready must line up with our tag; a slip means a latency mismatch
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (div_ready == tag_p[DIV_LAT-1].vld);
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural 3-cycle divider.
`timescale 1ns/1ps
module tb_div_share_ctrl;
    import div_share_ctrl_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int DW    = 36;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          busy;
    logic          div_valid;
    logic [DW-1:0] div_a;
    logic [DW-1:0] div_b;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_r;
    logic          div_ready;
    logic          div_inv;

    div_share_ctrl_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    div_share_ctrl #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .DW      (DW),
        .DIV_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .div_valid (div_valid),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_ready (div_ready),
        .div_inv   (div_inv)
    );

    always #5 clk = ~clk;

    // Behavioural divider: valid at T, ready/result at T+LAT
    logic          dm_v [LAT];
    logic [DW-1:0] dm_a [LAT];
    logic [DW-1:0] dm_b [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) dm_v[k] <= 1'b0;
        end else begin
            dm_v[0] <= div_valid;
            for (int k = 1; k < LAT; k++) dm_v[k] <= dm_v[k-1];
        end
        dm_a[0] <= div_a;
        dm_b[0] <= div_b;
        for (int k = 1; k < LAT; k++) begin
            dm_a[k] <= dm_a[k-1];
            dm_b[k] <= dm_b[k-1];
        end
    end

    assign div_ready = dm_v[LAT-1];
    assign div_inv   = (dm_b[LAT-1] == '0);
    assign div_q     = div_inv ? '0 : dm_a[LAT-1] / dm_b[LAT-1];
    assign div_r     = div_inv ? '0 : dm_a[LAT-1] % dm_b[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          err;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    logic [N_REQ-1:0] pend;
    logic [DW-1:0]    q2 [4];
    logic [DW-1:0]    r2 [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 36'd100,         36'd7,  36'd14,        36'd2,  1'b0};
        vecs[1] = '{3, 36'd55,          36'd0,  36'd0,         36'd0,  1'b1};
        vecs[2] = '{3, 36'd55,          36'd5,  36'd11,        36'd0,  1'b0};
        vecs[3] = '{0, 36'hF_FFFF_FFFF, 36'd1,  36'hF_FFFF_FFFF, 36'd0, 1'b0};
        vecs[4] = '{2, 36'd17,          36'd20, 36'd0,         36'd17, 1'b0};
        vecs[5] = '{2, 36'd0,           36'd9,  36'd0,         36'd0,  1'b0};
        q2 = '{36'd1000, 36'd500, 36'd333, 36'd250};
        r2 = '{36'd0, 36'd0, 36'd1, 36'd0};

        rst           = 1'b1;
        en            = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick();
        tick();
        at_neg();
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'h0);
        chk("rst_res_q",     64'(bus.res_q),     64'h0);
        chk("rst_res_r",     64'(bus.res_r),     64'h0);
        chk("rst_res_err",   64'(bus.res_err),   64'h0);
        chk("rst_busy",      64'(busy),          64'h0);
        chk("rst_div_valid", 64'(div_valid),     64'h0);
        tick();
        rst = 1'b0;

        // Single isolated ops, one per requester, including divide-by-zero
        for (int v = 0; v < NV; v++) begin
            bus.req_valid = N_REQ'(1 << vecs[v].id);
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            at_neg();
            chk("vec_grant",     64'(bus.req_ready), 64'(1 << vecs[v].id));
            chk("vec_div_valid", 64'(div_valid),     64'h1);
            chk("vec_div_a",     64'(div_a),         64'(vecs[v].a));
            chk("vec_div_b",     64'(div_b),         64'(vecs[v].b));
            tick();
            bus.req_valid = '0;
            at_neg();
            chk("vec_idle_valid", 64'(div_valid), 64'h0);
            chk("vec_hold_a",     64'(div_a),     64'(vecs[v].a));
            tick();
            tick();
            at_neg();
            chk("vec_early_res", 64'(bus.res_valid), 64'h0);
            chk("vec_busy",      64'(busy),          64'h1);
            tick();
            at_neg();
            chk("vec_res_valid", 64'(bus.res_valid), 64'(1 << vecs[v].id));
            chk("vec_res_q",     64'(bus.res_q),     64'(vecs[v].q));
            chk("vec_res_r",     64'(bus.res_r),     64'(vecs[v].r));
            chk("vec_res_err",   64'(bus.res_err),   64'(vecs[v].err));
            tick();
        end

        // All four at once: grants 0..3 back to back, results in issue order
        reset_dut();
        for (int i = 0; i < N_REQ; i++) set_op(i, 36'd1000, DW'(i + 1));
        pend = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            bus.req_valid = pend;
            at_neg();
            if (c < 4) chk("all_grant", 64'(bus.req_ready), 64'(1 << c));
            if (c >= 4 && c < 8) begin
                chk("all_res_valid", 64'(bus.res_valid), 64'(1 << (c - 4)));
                chk("all_res_q",     64'(bus.res_q),     64'(q2[c-4]));
                chk("all_res_r",     64'(bus.res_r),     64'(r2[c-4]));
            end
            tick();
            if (c < 4) pend = pend & ~N_REQ'(1 << c);
        end

        // Requesters 0 and 2 held continuously: must alternate
        set_op(0, 36'd80, 36'd8);
        set_op(2, 36'd90, 36'd9);
        for (int c = 0; c < 12; c++) begin
            bus.req_valid = (c < 8) ? 4'b0101 : 4'b0000;
            at_neg();
            if (c < 8) chk("alt_grant", 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h4);
            if (c >= 4) begin
                chk("alt_res_valid", 64'(bus.res_valid), (c % 2 == 0) ? 64'h1 : 64'h4);
                chk("alt_res_q",     64'(bus.res_q),     64'd10);
            end
            tick();
        end
        at_neg();
        chk("alt_busy_drained", 64'(busy), 64'h0);
        tick();

        // en low for 5 cycles with work pending; pointer must be remembered
        set_op(1, 36'd55, 36'd5);
        bus.req_valid = 4'b0010;
        at_neg();
        chk("en_pre_grant", 64'(bus.req_ready), 64'h2);
        tick();
        en = 1'b0;
        set_op(0, 36'd7, 36'd2);
        set_op(2, 36'd9, 36'd4);
        bus.req_valid = 4'b0101;
        for (int c = 1; c <= 5; c++) begin
            at_neg();
            chk("en_off_grant", 64'(bus.req_ready), 64'h0);
            chk("en_off_valid", 64'(div_valid),     64'h0);
            if (c == 4) begin
                chk("en_drain_res", 64'(bus.res_valid), 64'h2);
                chk("en_drain_q",   64'(bus.res_q),     64'd11);
                chk("en_drain_err", 64'(bus.res_err),   64'h0);
            end
            if (c == 5) chk("en_off_busy", 64'(busy), 64'h0);
            tick();
        end
        en = 1'b1;
        at_neg();
        chk("en_resume_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b0001;
        at_neg();
        chk("en_second_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        at_neg();
        chk("en_res2_valid", 64'(bus.res_valid), 64'h4);
        chk("en_res2_q",     64'(bus.res_q),     64'd2);
        chk("en_res2_r",     64'(bus.res_r),     64'd1);
        tick();
        at_neg();
        chk("en_res0_valid", 64'(bus.res_valid), 64'h1);
        chk("en_res0_q",     64'(bus.res_q),     64'd3);
        chk("en_res0_r",     64'(bus.res_r),     64'd1);
        tick();

        // Reset with three ops in flight: all discarded, pointer back to 0
        reset_dut();
        for (int i = 0; i < 3; i++) set_op(i, DW'(10 * (i + 1)), 36'd3);
        pend = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = pend;
            at_neg();
            chk("rstmid_grant", 64'(bus.req_ready), 64'(1 << c));
            tick();
            pend = pend & ~N_REQ'(1 << c);
        end
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            at_neg();
            chk("rstmid_no_res", 64'(bus.res_valid), 64'h0);
            chk("rstmid_busy",   64'(busy),          64'h0);
            tick();
        end
        set_op(2, 36'd21, 36'd7);
        set_op(3, 36'd22, 36'd7);
        bus.req_valid = 4'b1100;
        at_neg();
        chk("rstmid_first_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 6; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
